// File: rtl/trap_value_cause_regs.sv
// ============================================================================
// Module   : trap_value_cause_regs
// Purpose  : M/S trap value and cause CSRs with prioritised cause encoding,
//            LSU fault-address buffering and WARL-masked CSR write/set/clear.
// Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module trap_value_cause_regs #(
    parameter int XLEN     = 64,
    parameter int VA_W     = 39,
    parameter bit HAS_S    = 1'b1,
    parameter bit ILL_TVAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic            trap_target_s,
    input  logic            int_req,
    input  logic [4:0]      int_code,
    input  logic [1:0]      priv,
    input  logic [XLEN-1:0] ins_pc,
    input  logic [31:0]     ins_bits,
    input  logic            ins_page_fault,
    input  logic            ins_acc_fault,
    input  logic            ill_ins,
    input  logic            ins_addr_mis,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            st_addr_mis,
    input  logic            ld_addr_mis,
    input  logic            st_page_fault,
    input  logic            ld_page_fault,
    input  logic            st_acc_fault,
    input  logic            ld_acc_fault,
    input  logic            lsu_fault_vld,
    input  logic [VA_W-1:0] lsu_fault_addr,
    input  logic            flush,
    input  logic [1:0]      csr_op,
    input  logic [3:0]      csr_sel,
    input  logic [XLEN-1:0] data_csr,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] stval,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] scause,
    output logic            fault_held
);

    localparam logic [1:0] c_OP_NONE  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_SET   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    // Cause registers only keep the interrupt flag and the 5-bit code.
    localparam logic [XLEN-1:0] c_CAUSE_MASK = {1'b1, {(XLEN-6){1'b0}}, 5'h1F};

    logic [XLEN-1:0] mtval_q,  mtval_d;
    logic [XLEN-1:0] stval_q,  stval_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] scause_q, scause_d;
    logic [XLEN-1:0] fbuf_q,   fbuf_d;
    logic            held_q,   held_d;

    logic [XLEN-1:0] w_fault_addr_x;
    logic [XLEN-1:0] w_mem_tval;
    logic [XLEN-1:0] w_ill_tval;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_cause;
    logic [4:0]      w_code;
    logic            w_to_s;
    logic            w_csr_en;

    generate
        if (XLEN > VA_W) begin : g_sext
            assign w_fault_addr_x = {{(XLEN-VA_W){lsu_fault_addr[VA_W-1]}}, lsu_fault_addr};
        end else begin : g_trunc
            assign w_fault_addr_x = lsu_fault_addr[XLEN-1:0];
        end
    endgenerate

    // A fault address arriving in the trap cycle bypasses the buffer.
    assign w_mem_tval = lsu_fault_vld ? w_fault_addr_x :
                        (held_q ? fbuf_q : '0);
    assign w_ill_tval = ILL_TVAL ? XLEN'(ins_bits) : '0;
    assign w_to_s     = trap_target_s && HAS_S;
    assign w_csr_en   = (csr_op != c_OP_NONE) && !trap_valid;

    always_comb begin
        w_code = 5'd0;
        w_tval = '0;
        if (int_req) begin
            w_code = int_code;
        end else if (ins_page_fault) begin
            w_code = 5'd12;
            w_tval = ins_pc;
        end else if (ins_acc_fault) begin
            w_code = 5'd1;
            w_tval = ins_pc;
        end else if (ill_ins) begin
            w_code = 5'd2;
            w_tval = w_ill_tval;
        end else if (ins_addr_mis) begin
            w_code = 5'd0;
            w_tval = ins_pc;
        end else if (ecall) begin
            w_code = 5'd8 + {3'b000, priv};
        end else if (ebreak) begin
            w_code = 5'd3;
            w_tval = ins_pc;
        end else if (st_addr_mis) begin
            w_code = 5'd6;
            w_tval = w_mem_tval;
        end else if (ld_addr_mis) begin
            w_code = 5'd4;
            w_tval = w_mem_tval;
        end else if (st_page_fault) begin
            w_code = 5'd15;
            w_tval = w_mem_tval;
        end else if (ld_page_fault) begin
            w_code = 5'd13;
            w_tval = w_mem_tval;
        end else if (st_acc_fault) begin
            w_code = 5'd7;
            w_tval = w_mem_tval;
        end else if (ld_acc_fault) begin
            w_code = 5'd5;
            w_tval = w_mem_tval;
        end
    end

    always_comb begin
        w_cause            = '0;
        w_cause[4:0]       = w_code;
        w_cause[XLEN-1]    = int_req;
    end

    function automatic logic [XLEN-1:0] csr_apply(
        input logic [XLEN-1:0] cur,
        input logic [XLEN-1:0] opnd,
        input logic [1:0]      op
    );
        logic [XLEN-1:0] res;
        res = cur;
        case (op)
            c_OP_WRITE: res = opnd;
            c_OP_SET:   res = cur | opnd;
            c_OP_CLEAR: res = cur & ~opnd;
            default:    res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        mtval_d  = mtval_q;
        stval_d  = stval_q;
        mcause_d = mcause_q;
        scause_d = scause_q;
        if (trap_valid) begin
            if (w_to_s) begin
                stval_d  = w_tval;
                scause_d = w_cause;
            end else begin
                mtval_d  = w_tval;
                mcause_d = w_cause;
            end
        end else if (w_csr_en) begin
            if (csr_sel[0]) mtval_d  = csr_apply(mtval_q, data_csr, csr_op);
            if (csr_sel[1]) stval_d  = csr_apply(stval_q, data_csr, csr_op);
            if (csr_sel[2]) mcause_d = csr_apply(mcause_q, data_csr, csr_op) & c_CAUSE_MASK;
            if (csr_sel[3]) scause_d = csr_apply(scause_q, data_csr, csr_op) & c_CAUSE_MASK;
        end
        // Without S-mode the supervisor registers are hardwired to zero.
        if (!HAS_S) begin
            stval_d  = '0;
            scause_d = '0;
        end
    end

    always_comb begin
        fbuf_d = fbuf_q;
        held_d = held_q;
        if (trap_valid || flush) begin
            fbuf_d = '0;
            held_d = 1'b0;
        end else if (lsu_fault_vld) begin
            fbuf_d = w_fault_addr_x;
            held_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtval_q  <= '0;
            stval_q  <= '0;
            mcause_q <= '0;
            scause_q <= '0;
            fbuf_q   <= '0;
            held_q   <= 1'b0;
        end else begin
            mtval_q  <= mtval_d;
            stval_q  <= stval_d;
            mcause_q <= mcause_d;
            scause_q <= scause_d;
            fbuf_q   <= fbuf_d;
            held_q   <= held_d;
        end
    end

    assign mtval      = mtval_q;
    assign stval      = stval_q;
    assign mcause     = mcause_q;
    assign scause     = scause_q;
    assign fault_held = held_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_value_cause_regs.sv
// ============================================================================
// Module   : tb_trap_value_cause_regs
// Purpose  : Scoreboard bench for trap_value_cause_regs (default and M-only).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trap_value_cause_regs;

    localparam int c_A_MTVAL = 0, c_A_STVAL = 1, c_A_MCAUSE = 2, c_A_SCAUSE = 3, c_A_HELD = 4;
    localparam int c_B_MTVAL = 5, c_B_STVAL = 6, c_B_MCAUSE = 7, c_B_SCAUSE = 8, c_B_HELD = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, trap_target_s, int_req;
    logic [4:0]  int_code;
    logic [1:0]  priv;
    logic [63:0] ins_pc;
    logic [31:0] ins_bits;
    logic        ins_page_fault, ins_acc_fault, ill_ins, ins_addr_mis, ecall, ebreak;
    logic        st_addr_mis, ld_addr_mis, st_page_fault, ld_page_fault, st_acc_fault, ld_acc_fault;
    logic        lsu_fault_vld;
    logic [38:0] lsu_fault_addr;
    logic        flush;
    logic [1:0]  csr_op;
    logic [3:0]  csr_sel;
    logic [63:0] data_csr;
    logic [63:0] a_mtval, a_stval, a_mcause, a_scause;
    logic [63:0] b_mtval, b_stval, b_mcause, b_scause;
    logic        a_held, b_held;

    trap_value_cause_regs dut_a (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_target_s(trap_target_s),
        .int_req(int_req), .int_code(int_code), .priv(priv), .ins_pc(ins_pc),
        .ins_bits(ins_bits), .ins_page_fault(ins_page_fault), .ins_acc_fault(ins_acc_fault),
        .ill_ins(ill_ins), .ins_addr_mis(ins_addr_mis), .ecall(ecall), .ebreak(ebreak),
        .st_addr_mis(st_addr_mis), .ld_addr_mis(ld_addr_mis), .st_page_fault(st_page_fault),
        .ld_page_fault(ld_page_fault), .st_acc_fault(st_acc_fault), .ld_acc_fault(ld_acc_fault),
        .lsu_fault_vld(lsu_fault_vld), .lsu_fault_addr(lsu_fault_addr), .flush(flush),
        .csr_op(csr_op), .csr_sel(csr_sel), .data_csr(data_csr),
        .mtval(a_mtval), .stval(a_stval), .mcause(a_mcause), .scause(a_scause),
        .fault_held(a_held)
    );

    trap_value_cause_regs #(.HAS_S(1'b0), .ILL_TVAL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_target_s(trap_target_s),
        .int_req(int_req), .int_code(int_code), .priv(priv), .ins_pc(ins_pc),
        .ins_bits(ins_bits), .ins_page_fault(ins_page_fault), .ins_acc_fault(ins_acc_fault),
        .ill_ins(ill_ins), .ins_addr_mis(ins_addr_mis), .ecall(ecall), .ebreak(ebreak),
        .st_addr_mis(st_addr_mis), .ld_addr_mis(ld_addr_mis), .st_page_fault(st_page_fault),
        .ld_page_fault(ld_page_fault), .st_acc_fault(st_acc_fault), .ld_acc_fault(ld_acc_fault),
        .lsu_fault_vld(lsu_fault_vld), .lsu_fault_addr(lsu_fault_addr), .flush(flush),
        .csr_op(csr_op), .csr_sel(csr_sel), .data_csr(data_csr),
        .mtval(b_mtval), .stval(b_stval), .mcause(b_mcause), .scause(b_scause),
        .fault_held(b_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [63:0] get_out(input int sel);
        case (sel)
            c_A_MTVAL:  return a_mtval;
            c_A_STVAL:  return a_stval;
            c_A_MCAUSE: return a_mcause;
            c_A_SCAUSE: return a_scause;
            c_A_HELD:   return {63'd0, a_held};
            c_B_MTVAL:  return b_mtval;
            c_B_STVAL:  return b_stval;
            c_B_MCAUSE: return b_mcause;
            c_B_SCAUSE: return b_scause;
            default:    return {63'd0, b_held};
        endcase
    endfunction

    // Monitor: registered outputs are valid on the falling edge after the update edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = get_out(e.sel);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic ex(input string name, input int sel, input logic [63:0] v);
        exp_t e;
        e.due  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic clr_in();
        rst = 0; trap_valid = 0; trap_target_s = 0; int_req = 0; int_code = 0; priv = 2'd3;
        ins_pc = 0; ins_bits = 0; ins_page_fault = 0; ins_acc_fault = 0; ill_ins = 0;
        ins_addr_mis = 0; ecall = 0; ebreak = 0; st_addr_mis = 0; ld_addr_mis = 0;
        st_page_fault = 0; ld_page_fault = 0; st_acc_fault = 0; ld_acc_fault = 0;
        lsu_fault_vld = 0; lsu_fault_addr = 0; flush = 0; csr_op = 0; csr_sel = 0; data_csr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1; tick();
        rst = 1; tick();
        for (int i = 0; i < 10; i++) ex($sformatf("reset_out%0d", i), i, 64'd0);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h40_0000_1000; tick();
        ex("held_after_vld", c_A_HELD, 64'd1);

        trap_valid = 1; ld_page_fault = 1; tick();
        ex("ldpf_mtval", c_A_MTVAL, 64'hFFFF_FFC0_0000_1000);
        ex("ldpf_mcause", c_A_MCAUSE, 64'd13);
        ex("ldpf_held", c_A_HELD, 64'd0);
        ex("ldpf_b_mtval", c_B_MTVAL, 64'hFFFF_FFC0_0000_1000);

        trap_valid = 1; trap_target_s = 1; ins_acc_fault = 1; ill_ins = 1; ebreak = 1;
        ins_pc = 64'h8000_0040; ins_bits = 32'h1234_5678; tick();
        ex("prio_scause", c_A_SCAUSE, 64'd1);
        ex("prio_stval", c_A_STVAL, 64'h8000_0040);
        ex("prio_mtval_kept", c_A_MTVAL, 64'hFFFF_FFC0_0000_1000);
        ex("prio_mcause_kept", c_A_MCAUSE, 64'd13);
        ex("noS_mtval", c_B_MTVAL, 64'h8000_0040);
        ex("noS_mcause", c_B_MCAUSE, 64'd1);
        ex("noS_stval", c_B_STVAL, 64'd0);

        trap_valid = 1; ill_ins = 1; ins_bits = 32'hFFFF_FFFF; ins_pc = 64'h44; tick();
        ex("ill_mtval", c_A_MTVAL, 64'h0000_0000_FFFF_FFFF);
        ex("ill_mcause", c_A_MCAUSE, 64'd2);
        ex("ill_notval_mtval", c_B_MTVAL, 64'd0);

        trap_valid = 1; int_req = 1; int_code = 5'd5; ld_page_fault = 1; ins_pc = 64'h48; tick();
        ex("int_mcause", c_A_MCAUSE, 64'h8000_0000_0000_0005);
        ex("int_mtval", c_A_MTVAL, 64'd0);

        trap_valid = 1; ecall = 1; priv = 2'd1; ins_pc = 64'h4C; tick();
        ex("ecall_s_mcause", c_A_MCAUSE, 64'd9);
        trap_valid = 1; ecall = 1; ebreak = 1; priv = 2'd3; ins_pc = 64'h50; tick();
        ex("ecall_m_mcause", c_A_MCAUSE, 64'd11);
        ex("ecall_m_mtval", c_A_MTVAL, 64'd0);

        csr_op = 2'b01; csr_sel = 4'b0100; data_csr = '1; tick();
        ex("warl_write", c_A_MCAUSE, 64'h8000_0000_0000_001F);
        csr_op = 2'b11; csr_sel = 4'b0100; data_csr = 64'h10; tick();
        ex("warl_clear", c_A_MCAUSE, 64'h8000_0000_0000_000F);
        csr_op = 2'b10; csr_sel = 4'b0100; data_csr = 64'h20; tick();
        ex("warl_set", c_A_MCAUSE, 64'h8000_0000_0000_000F);

        csr_op = 2'b01; csr_sel = 4'b0001; data_csr = 64'h1234;
        trap_valid = 1; ebreak = 1; ins_pc = 64'h100; tick();
        ex("trap_wins_mtval", c_A_MTVAL, 64'h100);
        ex("trap_wins_mcause", c_A_MCAUSE, 64'd3);

        csr_op = 2'b01; csr_sel = 4'b0001; data_csr = 64'hDEAD; tick();
        ex("csr_wr_mtval", c_A_MTVAL, 64'hDEAD);
        csr_op = 2'b10; csr_sel = 4'b0001; data_csr = 64'hF_0000; tick();
        ex("csr_set_mtval", c_A_MTVAL, 64'hF_DEAD);
        ex("csr_set_b_mtval", c_B_MTVAL, 64'hF_DEAD);

        csr_op = 2'b01; csr_sel = 4'b0011; data_csr = 64'h55; tick();
        ex("multi_mtval", c_A_MTVAL, 64'h55);
        ex("multi_stval", c_A_STVAL, 64'h55);
        ex("multi_b_mtval", c_B_MTVAL, 64'h55);
        ex("multi_b_stval", c_B_STVAL, 64'd0);

        csr_op = 2'b01; csr_sel = 4'b1000; data_csr = '1; tick();
        ex("scause_warl", c_A_SCAUSE, 64'h8000_0000_0000_001F);
        ex("noS_scause", c_B_SCAUSE, 64'd0);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h123; trap_valid = 1; st_addr_mis = 1; tick();
        ex("bypass_mtval", c_A_MTVAL, 64'h123);
        ex("bypass_mcause", c_A_MCAUSE, 64'd6);
        ex("bypass_held", c_A_HELD, 64'd0);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h777; tick();
        ex("pre_flush_held", c_A_HELD, 64'd1);
        flush = 1; tick();
        ex("flush_held", c_A_HELD, 64'd0);
        trap_valid = 1; st_acc_fault = 1; tick();
        ex("flush_mtval", c_A_MTVAL, 64'd0);
        ex("flush_mcause", c_A_MCAUSE, 64'd7);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h999; flush = 1; tick();
        ex("flush_vs_vld", c_A_HELD, 64'd0);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h111; tick();
        lsu_fault_vld = 1; lsu_fault_addr = 39'h222; tick();
        trap_valid = 1; ld_acc_fault = 1; tick();
        ex("overwrite_mtval", c_A_MTVAL, 64'h222);
        ex("overwrite_mcause", c_A_MCAUSE, 64'd5);

        lsu_fault_vld = 1; lsu_fault_addr = 39'h333; tick();
        ex("mid_held", c_A_HELD, 64'd1);
        rst = 1; trap_valid = 1; ebreak = 1; ins_pc = 64'h200; tick();
        ex("midrst_held", c_A_HELD, 64'd0);
        ex("midrst_mcause", c_A_MCAUSE, 64'd0);
        ex("midrst_scause", c_A_SCAUSE, 64'd0);
        trap_valid = 1; st_page_fault = 1; tick();
        ex("post_rst_mtval", c_A_MTVAL, 64'd0);
        ex("post_rst_mcause", c_A_MCAUSE, 64'd15);

        trap_valid = 1; trap_target_s = 1; ecall = 1; priv = 2'd0; tick();
        ex("ecall_u_scause", c_A_SCAUSE, 64'd8);
        ex("ecall_u_mcause_kept", c_A_MCAUSE, 64'd15);
        ex("ecall_u_b_mcause", c_B_MCAUSE, 64'd8);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
